// File: rtl/tic_tac_toe_ctrl.sv
// Tic-tac-toe game controller.
//
// Holds the 3x3 board, takes moves from alternating players, rejects illegal
// moves, and after every accepted move spends one cycle checking the board for
// a winning line or a full-board draw.
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   new_game    one-cycle request to clear the board and restart
//   move_valid  move request qualifier
//   move_idx    target cell 1..9, row-major (1 = top-left)
//   move_ready  a move can be accepted this cycle (decode of state only)
//   X1..X9      cell contents as ASCII: "X", "O" or " "
//   turn_o      player to move: 0 = X, 1 = O
//   illegal     one-cycle pulse for a rejected move
//   game_over   game finished, held until a new game
//   winner      00 none, 01 X, 10 O, 11 draw
//   move_count  accepted moves in the current game, 0..9
module tic_tac_toe_ctrl #(
   parameter bit FIRST_O = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [3:0] move_idx,
   output logic       move_ready,
   output logic [0:7] X1,
   output logic [0:7] X2,
   output logic [0:7] X3,
   output logic [0:7] X4,
   output logic [0:7] X5,
   output logic [0:7] X6,
   output logic [0:7] X7,
   output logic [0:7] X8,
   output logic [0:7] X9,
   output logic       turn_o,
   output logic       illegal,
   output logic       game_over,
   output logic [1:0] winner,
   output logic [3:0] move_count
);

   typedef enum logic [1:0] {
      StPlay,
      StCheck,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      MarkEmpty = 2'b00,
      MarkX     = 2'b01,
      MarkO     = 2'b10
   } mark_e;

   localparam logic [1:0] WinNone = 2'b00;
   localparam logic [1:0] WinX    = 2'b01;
   localparam logic [1:0] WinO    = 2'b10;
   localparam logic [1:0] WinDraw = 2'b11;

   state_e     state_q, state_d;
   mark_e      cell_q [9];
   mark_e      cell_d [9];
   logic       turn_q, turn_d;
   logic       illegal_q, illegal_d;
   logic       game_over_q, game_over_d;
   logic [1:0] winner_q, winner_d;
   logic [3:0] count_q, count_d;

   mark_e mover;
   logic  target_free;
   logic  line_win;

   function automatic logic three(input mark_e a, input mark_e b, input mark_e c,
                                  input mark_e m);
      return (a == m) && (b == m) && (c == m);
   endfunction

   function automatic logic [7:0] to_ascii(input mark_e m);
      unique case (m)
         MarkX:   return 8'h58;
         MarkO:   return 8'h4F;
         default: return 8'h20;
      endcase
   endfunction

   assign mover = turn_q ? MarkO : MarkX;

   // Only the player who just moved can have completed a line.
   always_comb begin
      line_win = three(cell_q[0], cell_q[1], cell_q[2], mover) |
                 three(cell_q[3], cell_q[4], cell_q[5], mover) |
                 three(cell_q[6], cell_q[7], cell_q[8], mover) |
                 three(cell_q[0], cell_q[3], cell_q[6], mover) |
                 three(cell_q[1], cell_q[4], cell_q[7], mover) |
                 three(cell_q[2], cell_q[5], cell_q[8], mover) |
                 three(cell_q[0], cell_q[4], cell_q[8], mover) |
                 three(cell_q[2], cell_q[4], cell_q[6], mover);
   end

   // Out-of-range indices never match a cell, so they read as not free.
   always_comb begin
      target_free = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (move_idx == 4'(i + 1)) begin
            target_free = (cell_q[i] == MarkEmpty);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cell_d      = cell_q;
      turn_d      = turn_q;
      illegal_d   = 1'b0;
      game_over_d = game_over_q;
      winner_d    = winner_q;
      count_d     = count_q;

      if (new_game) begin
         state_d = StPlay;
         for (int i = 0; i < 9; i++) begin
            cell_d[i] = MarkEmpty;
         end
         turn_d      = FIRST_O;
         game_over_d = 1'b0;
         winner_d    = WinNone;
         count_d     = 4'd0;
      end else begin
         unique case (state_q)
            StPlay: begin
               if (move_valid) begin
                  if (target_free) begin
                     for (int i = 0; i < 9; i++) begin
                        if (move_idx == 4'(i + 1)) begin
                           cell_d[i] = mover;
                        end
                     end
                     count_d = (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
                     state_d = StCheck;
                  end else begin
                     illegal_d = 1'b1;
                  end
               end
            end
            StCheck: begin
               if (line_win) begin
                  winner_d    = turn_q ? WinO : WinX;
                  game_over_d = 1'b1;
                  state_d     = StDone;
               end else if (count_q == 4'd9) begin
                  winner_d    = WinDraw;
                  game_over_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = StPlay;
               end
            end
            StDone: begin
               state_d = StDone;
            end
            default: begin
               state_d = StPlay;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StPlay;
         for (int i = 0; i < 9; i++) begin
            cell_q[i] <= MarkEmpty;
         end
         turn_q      <= FIRST_O;
         illegal_q   <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= WinNone;
         count_q     <= 4'd0;
      end else begin
         state_q     <= state_d;
         cell_q      <= cell_d;
         turn_q      <= turn_d;
         illegal_q   <= illegal_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
         count_q     <= count_d;
      end
   end

   assign move_ready = (state_q == StPlay);
   assign X1         = to_ascii(cell_q[0]);
   assign X2         = to_ascii(cell_q[1]);
   assign X3         = to_ascii(cell_q[2]);
   assign X4         = to_ascii(cell_q[3]);
   assign X5         = to_ascii(cell_q[4]);
   assign X6         = to_ascii(cell_q[5]);
   assign X7         = to_ascii(cell_q[6]);
   assign X8         = to_ascii(cell_q[7]);
   assign X9         = to_ascii(cell_q[8]);
   assign turn_o     = turn_q;
   assign illegal    = illegal_q;
   assign game_over  = game_over_q;
   assign winner     = winner_q;
   assign move_count = count_q;

endmodule

// File: tb/tb_tic_tac_toe_ctrl.sv
// Directed bench for tic_tac_toe_ctrl: one instance with X first, one with O
// first, driven after each rising edge and sampled 1 ns after the edge.
module tb_tic_tac_toe_ctrl;

   logic       clk;
   logic       rst_n;
   logic       new_game, move_valid;
   logic [3:0] move_idx;
   logic       move_ready, turn_o, illegal, game_over;
   logic [1:0] winner;
   logic [3:0] move_count;
   logic [0:7] X1, X2, X3, X4, X5, X6, X7, X8, X9;
   logic [7:0] cells [9];

   logic       b_new_game, b_move_valid;
   logic [3:0] b_move_idx;
   logic       b_move_ready, b_turn_o, b_illegal, b_game_over;
   logic [1:0] b_winner;
   logic [3:0] b_move_count;
   logic [0:7] B1, B2, B3, B4, B5, B6, B7, B8, B9;
   logic [7:0] b_cells [9];

   int n_checks = 0;
   int n_pass   = 0;

   tic_tac_toe_ctrl #(.FIRST_O(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .new_game(new_game), .move_valid(move_valid),
      .move_idx(move_idx), .move_ready(move_ready),
      .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7), .X8(X8), .X9(X9),
      .turn_o(turn_o), .illegal(illegal), .game_over(game_over), .winner(winner),
      .move_count(move_count)
   );

   tic_tac_toe_ctrl #(.FIRST_O(1'b1)) dut_o (
      .clk(clk), .rst_n(rst_n), .new_game(b_new_game), .move_valid(b_move_valid),
      .move_idx(b_move_idx), .move_ready(b_move_ready),
      .X1(B1), .X2(B2), .X3(B3), .X4(B4), .X5(B5), .X6(B6), .X7(B7), .X8(B8), .X9(B9),
      .turn_o(b_turn_o), .illegal(b_illegal), .game_over(b_game_over), .winner(b_winner),
      .move_count(b_move_count)
   );

   assign cells[0] = X1;
   assign cells[1] = X2;
   assign cells[2] = X3;
   assign cells[3] = X4;
   assign cells[4] = X5;
   assign cells[5] = X6;
   assign cells[6] = X7;
   assign cells[7] = X8;
   assign cells[8] = X9;
   assign b_cells[0] = B1;
   assign b_cells[1] = B2;
   assign b_cells[2] = B3;
   assign b_cells[3] = B4;
   assign b_cells[4] = B5;
   assign b_cells[5] = B6;
   assign b_cells[6] = B7;
   assign b_cells[7] = B8;
   assign b_cells[8] = B9;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Expected board as a 9-character string of 'X', 'O' and ' '.
   task automatic check_board(input string tag, input string exp);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("%s cell%0d", tag, i + 1), {24'd0, cells[i]}, {24'd0, exp[i]});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one move, then let the CHECK cycle run.
   task automatic do_move(input logic [3:0] idx);
      move_valid = 1'b1;
      move_idx   = idx;
      tick();
      move_valid = 1'b0;
      tick();
   endtask

   task automatic start_game();
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      new_game     = 1'b0;
      move_valid   = 1'b0;
      move_idx     = 4'd0;
      b_new_game   = 1'b0;
      b_move_valid = 1'b0;
      b_move_idx   = 4'd0;
      tick();
      tick();

      // Reset state
      check("rst ready", move_ready, 1);
      check("rst turn", turn_o, 0);
      check("rst count", move_count, 0);
      check("rst winner", winner, 0);
      check("rst over", game_over, 0);
      check("rst illegal", illegal, 0);
      check_board("rst", "         ");
      check("rst turn O-first", b_turn_o, 1);
      rst_n = 1'b1;
      tick();

      // Illegal moves: 5, 5 again, 0, 10
      move_valid = 1'b1;
      move_idx   = 4'd5;
      tick();
      move_valid = 1'b0;
      check("m5 illegal", illegal, 0);
      check("m5 ready in check", move_ready, 0);
      check("m5 count", move_count, 1);
      tick();
      check("m5 turn", turn_o, 1);
      check("m5 ready", move_ready, 1);
      move_valid = 1'b1;
      move_idx   = 4'd5;
      tick();
      check("dup illegal", illegal, 1);
      check("dup ready", move_ready, 1);
      move_valid = 1'b0;
      tick();
      check("illegal one cycle", illegal, 0);
      move_valid = 1'b1;
      move_idx   = 4'd0;
      tick();
      check("idx0 illegal", illegal, 1);
      move_idx = 4'd10;
      tick();
      check("idx10 illegal", illegal, 1);
      move_valid = 1'b0;
      tick();
      check("ill turn", turn_o, 1);
      check("ill count", move_count, 1);
      check_board("ill", "    X    ");

      // X row win: 1,4,2,5,3
      start_game();
      check("ng count", move_count, 0);
      check("ng turn", turn_o, 0);
      check_board("ng", "         ");
      do_move(4'd1);
      do_move(4'd4);
      do_move(4'd2);
      do_move(4'd5);
      check("row 4th over", game_over, 0);
      move_valid = 1'b1;
      move_idx   = 4'd3;
      tick();
      move_valid = 1'b0;
      check("row check winner", winner, 0);
      tick();
      check("row winner", winner, 2'b01);
      check("row over", game_over, 1);
      check("row count", move_count, 5);
      check("row turn", turn_o, 0);
      check("row ready", move_ready, 0);
      check_board("row", "XXXOO    ");

      // Post-game move ignored
      move_valid = 1'b1;
      move_idx   = 4'd9;
      tick();
      move_valid = 1'b0;
      check("post illegal", illegal, 0);
      check("post count", move_count, 5);
      check("post X9", {24'd0, X9}, 32'h20);
      check("post winner", winner, 2'b01);

      // Draw: 1,2,3,5,4,6,8,7,9
      start_game();
      check("ng2 over", game_over, 0);
      check("ng2 winner", winner, 0);
      do_move(4'd1);
      do_move(4'd2);
      do_move(4'd3);
      do_move(4'd5);
      do_move(4'd4);
      do_move(4'd6);
      do_move(4'd8);
      do_move(4'd7);
      do_move(4'd9);
      check("draw winner", winner, 2'b11);
      check("draw over", game_over, 1);
      check("draw count", move_count, 9);
      check_board("draw", "XOXXOOOXX");

      // O-first instance: new_game beats a same-cycle move
      b_new_game = 1'b1;
      tick();
      b_new_game   = 1'b0;
      b_move_valid = 1'b1;
      b_move_idx   = 4'd1;
      tick();
      b_move_valid = 1'b0;
      tick();
      check("ofirst mark", {24'd0, b_cells[0]}, 32'h4F);
      check("ofirst turn", b_turn_o, 0);
      b_new_game   = 1'b1;
      b_move_valid = 1'b1;
      b_move_idx   = 4'd2;
      tick();
      b_new_game   = 1'b0;
      b_move_valid = 1'b0;
      check("ngmv count", b_move_count, 0);
      check("ngmv turn", b_turn_o, 1);
      check("ngmv illegal", b_illegal, 0);
      check("ngmv ready", b_move_ready, 1);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("ngmv cell%0d", i + 1), {24'd0, b_cells[i]}, 32'h20);
      end

      // Reset during the CHECK of a winning move
      start_game();
      do_move(4'd1);
      do_move(4'd4);
      do_move(4'd2);
      do_move(4'd5);
      move_valid = 1'b1;
      move_idx   = 4'd3;
      tick();
      move_valid = 1'b0;
      rst_n      = 1'b0;
      tick();
      check("rchk winner", winner, 0);
      check("rchk over", game_over, 0);
      check("rchk count", move_count, 0);
      check("rchk turn", turn_o, 0);
      check("rchk ready", move_ready, 1);
      check_board("rchk", "         ");
      rst_n = 1'b1;
      tick();
      check("rchk stays", winner, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tic_tac_toe_ctrl.md
TIC_TAC_TOE_CTRL -- requirements
Module: tic_tac_toe_ctrl

Interface
REQ-001 Parameter FIRST_O, default 0, meaning: 0 = "X" moves first after reset or new game, 1 = "O" moves first.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 new_game  input  1  one-cycle request to clear the board and start a new game.
REQ-005 move_valid  input  1  move request qualifier.
REQ-006 move_idx  input  4  target cell, 1..9 row-major (1 = top-left, 9 = bottom-right).
REQ-007 move_ready  output  1  controller can accept a move this cycle.
REQ-008 X1..X9  output  8 each, declared [0:7]  cell contents as ASCII: "X" (8'h58), "O" (8'h4F), empty " " (8'h20); directly drives the tic_tac_toe evaluator inputs.
REQ-009 turn_o  output  1  player to move: 0 = X, 1 = O.
REQ-010 illegal  output  1  one-cycle pulse flagging a rejected move.
REQ-011 game_over  output  1  game finished; held high until a new game starts.
REQ-012 winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-013 move_count  output  4  number of accepted moves in the current game, 0..9.

Function
REQ-014 FSM states: PLAY, CHECK, DONE; encoding is free.
REQ-015 PLAY: move_ready=1; all other states: move_ready=0.
REQ-016 A move is offered when move_valid=1 and move_ready=1.
REQ-017 Legal move: move_idx in 1..9 and the target cell is " ".
REQ-018 Legal move, next edge: the target cell takes the current player's mark, move_count increments, and the FSM goes to CHECK.
REQ-019 Illegal move (idx 0 or 10..15, or cell occupied), next edge: illegal=1 for one cycle; board, turn_o and move_count unchanged; FSM stays in PLAY.
REQ-020 move_valid when move_ready=0 is ignored: no board change, no illegal pulse.
REQ-021 CHECK lasts exactly one cycle and evaluates the 8 lines (3 rows, 3 columns, 2 diagonals) on the registered board.
REQ-022 CHECK, line of three equal marks by the mover: winner = mover (01/10), game_over=1, next state DONE, turn_o unchanged.
REQ-023 CHECK, no line and move_count=9: winner=11, game_over=1, next state DONE.
REQ-024 CHECK, otherwise: turn_o toggles and the FSM returns to PLAY.
REQ-025 Accept-to-accept latency is 2 cycles (PLAY -> CHECK -> PLAY); winner/game_over update on the edge leaving CHECK.
REQ-026 DONE: the board, winner, game_over and move_count hold; moves are ignored per REQ-020.
REQ-027 new_game=1 in any state, next edge: all cells " ", move_count=0, winner=00, game_over=0, illegal=0, turn_o=FIRST_O, state PLAY.
REQ-028 new_game and move_valid in the same cycle: new_game has priority and the move is dropped silently.
REQ-029 move_count saturates at 9; a move cannot be accepted at 9 because the FSM always leaves PLAY for DONE at that point.
REQ-030 All outputs are registered; there are no combinational paths from inputs to outputs except move_ready, which is a decode of state only.

Reset
REQ-031 rst_n=0 at a clock edge: state PLAY, all cells " ", turn_o=FIRST_O, move_count=0, winner=00, game_over=0, illegal=0.
REQ-032 Reset has priority over new_game and moves, and aborts a game mid-CHECK with no winner update.

Verification
REQ-033 X row win: moves 1,4,2,5,3 (X first) -> after the 5th CHECK, winner=01, game_over=1, X1..X3="X", X4..X5="O", move_count=5.
REQ-034 Draw: moves 1,2,3,5,4,6,8,7,9 -> board XOX/XOO/OXX, i.e. X1="X", X2="O", X3="X", X4="X", X5="O", X6="O", X7="O", X8="X", X9="X"; winner=11; move_count=9; the tic_tac_toe evaluator F is sampled on this board.
REQ-035 Illegal moves: move 5, then move 5 again, then move_idx=0 -> illegal pulses exactly twice, X5="X", turn_o=1, move_count=1.
REQ-036 Post-game move: after REQ-033 completes, a move to cell 9 -> ignored, X9=" ", no illegal pulse.
REQ-037 new_game and move_valid in the same cycle mid-game -> board all " ", move_count=0, no mark placed; with FIRST_O=1, turn_o=1.
REQ-038 rst_n=0 during CHECK of a winning move -> all outputs at reset values, winner=00.
